// File: rtl/alu_result_stage_if.sv
// ALU result stage bus: upstream push side, downstream pop side and delivered count.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// master = environment (drives inputs, sees status); slave = the result stage.
interface alu_result_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     result;
  logic                 select1;
  logic                 select0;
  logic                 carry_in;
  logic                 ovf_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [1:0]           out_op;
  logic                 flag_zero;
  logic                 flag_neg;
  logic                 flag_carry;
  logic                 flag_ovf;
  logic [CNT_WIDTH-1:0] op_count;

  modport master (
    output in_valid, result, select1, select0, carry_in, ovf_in, out_ready,
    input  in_ready, out_valid, out_result, out_op,
           flag_zero, flag_neg, flag_carry, flag_ovf, op_count
  );

  modport slave (
    input  in_valid, result, select1, select0, carry_in, ovf_in, out_ready,
    output in_ready, out_valid, out_result, out_op,
           flag_zero, flag_neg, flag_carry, flag_ovf, op_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures mux result + op + carry/ovf, stores flags in a 2-entry FIFO.
// Latency: 1 cycle (push at edge N -> out_valid in cycle N+1), no bypass.
// Backpressure: in_ready = (count != 2) from registered count only; head holds while out_ready=0.
// Ports: clk, reset (sync, active-high); bus (slave modport): in_valid/in_ready/result/select1/
// select0/carry_in/ovf_in upstream, out_valid/out_ready/out_result/out_op/flag_* downstream, op_count.
module alu_result_stage #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,  // fixed at 2; other values are not supported
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [1:0]       op;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
  } entry_t;

  // Shift structure: head is the oldest entry and directly drives the outputs,
  // second is only meaningful when count == 2.
  entry_t               head_q, head_d;
  entry_t               second_q, second_d;
  logic [1:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  logic   push;
  logic   pop;
  entry_t new_entry;

  assign bus.in_ready  = (count_q != 2'(DEPTH));
  assign bus.out_valid = (count_q != 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Flags are derived here, at capture time, so the output side is pure register.
  // Logic ops (select1=0) have no meaningful carry/overflow and are masked.
  always_comb begin
    new_entry       = '0;
    new_entry.res   = bus.result;
    new_entry.op    = {bus.select1, bus.select0};
    new_entry.carry = bus.select1 & bus.carry_in;
    new_entry.ovf   = bus.select1 & bus.ovf_in;
    new_entry.zero  = (bus.result == '0);
    new_entry.neg   = bus.result[WIDTH-1];
  end

  always_comb begin
    head_d     = head_q;
    second_d   = second_q;
    count_d    = count_q + 2'(push) - 2'(pop);
    op_count_d = op_count_q + CNT_WIDTH'(pop);
    if (pop) begin
      if (count_q == 2'd2) begin
        head_d = second_q;
      end else if (push) begin
        // count 1 with push+pop: the new entry replaces the departing head.
        head_d = new_entry;
      end
      // count 1 pop-only: head keeps its last popped value while empty.
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d = new_entry;
      end else begin
        second_d = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      second_q   <= '0;
      count_q    <= 2'd0;
      op_count_q <= '0;
    end else begin
      head_q     <= head_d;
      second_q   <= second_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.out_result = head_q.res;
  assign bus.out_op     = head_q.op;
  assign bus.flag_zero  = head_q.zero;
  assign bus.flag_neg   = head_q.neg;
  assign bus.flag_carry = head_q.carry;
  assign bus.flag_ovf   = head_q.ovf;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  op;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic clk;
  logic reset;
  logic rst2;

  int errors = 0;
  int checks = 0;

  exp_t        q[$];
  int          occ = 0;
  logic [15:0] exp_cnt = '0;
  bit          was_rst = 1'b0;

  alu_result_stage_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();
  alu_result_stage_if #(.WIDTH(32), .CNT_WIDTH(4))  bus2 ();

  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_WIDTH(4)) dut_wrap (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the consumer should see for a given issued operation.
  function automatic exp_t model(input logic [31:0] r, input logic [1:0] op,
                                 input logic c, input logic v);
    exp_t e;
    bit   arith;
    arith = (op == 2'b10) || (op == 2'b11);
    e.res = r;
    e.op  = op;
    e.c   = arith ? c : 1'b0;
    e.v   = arith ? v : 1'b0;
    e.z   = (r == 32'd0);
    e.n   = (r >= 32'h8000_0000);
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold an operation on the upstream side until it is accepted.
  task automatic send(input logic [31:0] r, input logic [1:0] op, input logic c, input logic v);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.result   = r;
    bus.select1  = op[1];
    bus.select0  = op[0];
    bus.carry_in = c;
    bus.ovf_in   = v;
    while (!bus.in_ready) begin
      cyc(1);
      guard++;
      if (guard > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck 0 for value %0h", r);
        break;
      end
    end
    if (bus.in_ready) q.push_back(model(r, op, c, v));
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: occupancy/count checks each cycle, data checks on every pop.
  always @(negedge clk) begin
    bit   push;
    bit   pop;
    exp_t e;
    if (reset) begin
      occ     = 0;
      exp_cnt = '0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_op", 64'(bus.out_op), 64'd0);
        chk("rst_flags", 64'({bus.flag_zero, bus.flag_neg, bus.flag_carry, bus.flag_ovf}), 64'd0);
        was_rst = 1'b0;
      end
      chk("in_ready", 64'(bus.in_ready), 64'(occ != 2));
      chk("out_valid", 64'(bus.out_valid), 64'(occ != 0));
      chk("op_count", 64'(bus.op_count), 64'(exp_cnt));
      pop  = (occ != 0) && bus.out_ready;
      push = bus.in_valid && (occ != 2);
      if (pop) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: pop seen with no expected entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("out_result", 64'(bus.out_result), 64'(e.res));
          chk("out_op", 64'(bus.out_op), 64'(e.op));
          chk("flag_zero", 64'(bus.flag_zero), 64'(e.z));
          chk("flag_neg", 64'(bus.flag_neg), 64'(e.n));
          chk("flag_carry", 64'(bus.flag_carry), 64'(e.c));
          chk("flag_ovf", 64'(bus.flag_ovf), 64'(e.v));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      occ = occ + int'(push) - int'(pop);
    end
  end

  initial begin
    int pops;
    int guard;
    reset = 1'b1;
    rst2  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.result    = '0;
    bus.select1   = 1'b0;
    bus.select0   = 1'b0;
    bus.carry_in  = 1'b0;
    bus.ovf_in    = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.result    = '0;
    bus2.select1   = 1'b0;
    bus2.select0   = 1'b0;
    bus2.carry_in  = 1'b0;
    bus2.ovf_in    = 1'b0;
    bus2.out_ready = 1'b0;

    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Single ADD, then logic-op masking, then SUB with overflow.
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0);
    cyc(2);
    send(32'h0, 2'b00, 1'b1, 1'b1);
    send(32'h7FFF_0000, 2'b01, 1'b1, 1'b1);
    send(32'h8000_0000, 2'b11, 1'b0, 1'b1);
    cyc(2);

    // Backpressure: two entries fill the stage, a third is held off.
    bus.out_ready = 1'b0;
    send(32'h11, 2'b10, 1'b0, 1'b0);
    send(32'h22, 2'b11, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.result   = 32'h33;
    bus.select1  = 1'b0;
    bus.select0  = 1'b1;
    cyc(3);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_head_hold", 64'(bus.out_result), 64'h11);
    bus.out_ready = 1'b1;
    send(32'h33, 2'b01, 1'b0, 1'b0);
    cyc(4);
    chk("bp_op_count", 64'(bus.op_count), 64'(exp_cnt));

    // Continuous streaming at count 1.
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 2'(i), 1'b1, 1'b1);
    cyc(3);

    // Reset with two buffered entries and a push pending.
    bus.out_ready = 1'b0;
    send(32'hAAAA_0001, 2'b10, 1'b1, 1'b1);
    send(32'hAAAA_0002, 2'b11, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.result   = 32'hDEAD_BEEF;
    reset = 1'b1;
    q.delete();
    cyc(1);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    cyc(1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_op_count", 64'(bus.op_count), 64'd0);
    cyc(2);

    // Randomized traffic with random consumer stalls.
    fork
      begin
        repeat (500) begin
          cyc(1);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        repeat (150) begin
          if ($urandom_range(0, 2) == 0) cyc(1);
          send($urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
      end
    join
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      cyc(1);
      guard++;
    end
    cyc(2);
    chk("drain_leftover", 64'(q.size()), 64'd0);

    // Counter wrap on the 4-bit instance: 17 pops -> 1.
    cyc(1);
    rst2 = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.result    = 32'h5;
    bus2.out_ready = 1'b1;
    pops  = 0;
    guard = 0;
    while (pops < 17 && guard < 100) begin
      @(negedge clk);
      if (bus2.out_valid && bus2.out_ready) pops++;
      guard++;
    end
    @(posedge clk);
    #1;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b0;
    chk("wrap_pops", 64'(pops), 64'd17);
    @(negedge clk);
    chk("wrap_op_count", 64'(bus2.op_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit ALU's bit-sliced 4:1 select muxes.
- Captures the 32-bit mux result together with the 2-bit operation select and the adder's carry/overflow, then derives the status flags.
- Buffers up to two results in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Counts delivered results, so the ALU datapath can stall cleanly against a slow consumer.

Parameters:
- WIDTH, 32, datapath width of result and out_result.
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported.
- CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept an entry this cycle.
- result  input  WIDTH  ALU mux-array output.
- select1  input  1  op select MSB (same encoding as the mux stage).
- select0  input  1  op select LSB.
- carry_in  input  1  adder carry-out for this result.
- ovf_in  input  1  adder signed overflow for this result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_result  output  WIDTH  head entry result.
- out_op  output  2  head entry {select1, select0}.
- flag_zero  output  1  head result == 0.
- flag_neg  output  1  head result[WIDTH-1].
- flag_carry  output  1  head carry; 0 for logic ops.
- flag_ovf  output  1  head overflow; 0 for logic ops.
- op_count  output  CNT_WIDTH  number of entries popped since reset.

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - count=0, out_valid=0, in_ready=1.
  - out_result=0, out_op=0, all flags=0, op_count=0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-transfer discards all buffered entries.
- Op encoding {select1,select0}: 00 AND, 01 OR, 10 ADD, 11 SUB.
  - select1=1 is arithmetic: carry/ovf are stored as given.
  - select1=0 is logic: carry/ovf are stored as 0.
- Flag computation:
  - zero and neg are computed from result at push time and stored per entry.
  - No flag is computed combinationally from out_result.
- Handshake rules:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
- Status signals:
  - in_ready = (count != 2), driven from the registered count only; no combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible on the outputs after edge N, with out_valid high in cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO; the head is the oldest entry.
- Count transitions:
  - count 0: push → 1.
  - count 1: push only → 2; pop only → 0; push+pop → 1, and the new entry becomes the head next cycle.
  - count 2: in_ready=0, so no push; pop → 1 and the second entry moves to the head.
- Stability: while out_valid && !out_ready, out_result, out_op and all flags hold unchanged.
- Empty outputs: when count=0, out_result, out_op and the flags hold their last popped value, or 0 after reset; consumers ignore them when out_valid=0.
- in_valid without in_ready is ignored; upstream must hold its data.
- op_count:
  - Increments by 1 on each pop.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Not affected by push.
- Implementation: two entry registers plus head/tail pointers, or a shift structure; either is acceptable if the above holds.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → in_ready=1, out_valid=0, out_result=0, op_count=0.
- Single ADD: push result=0xFFFFFFFF, op=10, carry_in=1, ovf_in=0, out_ready=1 → next cycle out_valid=1, out_result=0xFFFFFFFF, flag_neg=1, flag_carry=1, flag_zero=0; one cycle later op_count=1, out_valid=0.
- Logic-op masking: push result=0, op=00, carry_in=1, ovf_in=1 → flag_zero=1, flag_carry=0, flag_ovf=0.
- Backpressure: out_ready=0, push 0x11 then 0x22 → in_ready=0 after the second push; a third in_valid with 0x33 is not accepted; outputs hold 0x11; raise out_ready → 0x11, 0x22, 0x33 delivered in order and op_count=3.
- Simultaneous push/pop at count=1: stream 8 results with in_valid=1 and out_ready=1 continuously → one result per cycle, in order, count stays 1, in_ready stays 1.
- Mid-operation reset: with 2 entries buffered and out_ready=0, assert reset while in_valid=1 → next cycle count=0, out_valid=0, op_count=0, and the pushed entry is dropped.
- Counter wrap (CNT_WIDTH=4 override): perform 17 pops → op_count=1.
